// File: rtl/sporta_unpack.sv
//------------------------------------------------------------------------------
// sporta_unpack: rebuilds TLC3548 / AD7794 readings from the serial-port byte
// stream into a 12-entry result bank with a registered host read port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sporta_unpack #(
  parameter int FAST_BITS = 14,
  parameter int SLOW_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] stream,
  input  logic        stream_tick,
  input  logic [3:0]  rd_addr,
  output logic [23:0] rd_data,
  output logic        rd_valid,
  output logic        scan_done,
  output logic [7:0]  scan_seq,
  output logic        fmt_err
);

  localparam int         WORD_BITS   = 24;
  localparam int         NUM_ENTRIES = 12;
  localparam logic [3:0] SLOT_FAST_LO = 4'd2;
  localparam logic [3:0] SLOT_FAST_HI = 4'd9;
  localparam logic [3:0] SLOT_SLOW    = 4'd10;
  localparam logic [3:0] BIDX_MAX     = 4'd15;
  localparam logic [3:0] LAST_FAST    = 4'd7;

  // Stream field decode
  logic [1:0] slow_chan;
  logic       slow_last;
  logic [3:0] slot;
  logic       byte0;
  logic [7:0] rx_byte;

  assign slow_chan = stream[15:14];
  assign slow_last = stream[13];
  assign slot      = stream[12:9];
  assign byte0     = stream[8];
  assign rx_byte   = stream[7:0];

  logic [3:0]  bidx;
  logic        synced;
  logic [7:0]  fast_hi;
  logic [15:0] slow_sr;

  logic        wr_pend;
  logic [3:0]  wr_addr;
  logic [WORD_BITS-1:0] wr_word;

  logic [3:0]  bidx_inc;
  logic [3:0]  bidx_next;
  logic        slot_bad;
  logic        data_ok;
  logic        is_fast;
  logic        is_slow;
  logic [3:0]  fast_slot_ofs;
  logic [15:0] fast_pair;
  logic [23:0] slow_full;

  assign slot_bad      = (slot > SLOT_SLOW);
  assign bidx_inc      = (bidx == BIDX_MAX) ? BIDX_MAX : bidx + 4'd1;
  assign bidx_next     = byte0 ? 4'd0 : bidx_inc;
  // Data bytes count only once a byte0 has been seen since reset.
  assign data_ok       = stream_tick && !slot_bad && !byte0 && synced;
  assign is_fast       = (slot >= SLOT_FAST_LO) && (slot <= SLOT_FAST_HI);
  assign is_slow       = (slot == SLOT_SLOW) && slow_last;
  assign fast_slot_ofs = slot - SLOT_FAST_LO;
  assign fast_pair     = {fast_hi, rx_byte};
  assign slow_full     = {slow_sr, rx_byte};

  // Byte tracking and assembly; a completed word is staged for the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      bidx    <= 4'd0;
      synced  <= 1'b0;
      fast_hi <= 8'd0;
      slow_sr <= 16'd0;
      wr_pend <= 1'b0;
      wr_addr <= 4'd0;
      wr_word <= '0;
      fmt_err <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (stream_tick) begin
        if (slot_bad) begin
          fmt_err <= 1'b1;
        end else begin
          bidx <= bidx_next;
          if (byte0) begin
            synced <= 1'b1;
          end else if (bidx_inc == BIDX_MAX) begin
            fmt_err <= 1'b1;
          end
        end
      end

      if (data_ok && is_fast) begin
        if (bidx_next == 4'd1) begin
          fast_hi <= rx_byte;
        end else if (bidx_next == 4'd2) begin
          wr_pend <= 1'b1;
          wr_addr <= {1'b0, fast_slot_ofs[2:0]};
          wr_word <= WORD_BITS'(fast_pair[15 -: FAST_BITS]);
        end
      end

      if (data_ok && is_slow) begin
        if ((bidx_next >= 4'd1) && (bidx_next <= 4'd3)) begin
          slow_sr <= slow_full[15:0];
        end
        if (bidx_next == 4'd3) begin
          wr_pend <= 1'b1;
          wr_addr <= {2'b10, slow_chan};
          wr_word <= WORD_BITS'(slow_full[23 -: SLOW_BITS]);
        end
      end
    end
  end

  logic [WORD_BITS-1:0]   bank [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] bank_valid;

  // Bank write, scan bookkeeping and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        bank[i] <= '0;
      end
      bank_valid <= '0;
      scan_done  <= 1'b0;
      scan_seq   <= 8'd0;
      rd_data    <= 24'd0;
      rd_valid   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (wr_pend) begin
        bank[wr_addr]       <= wr_word;
        bank_valid[wr_addr] <= 1'b1;
        if (wr_addr == LAST_FAST) begin
          scan_done <= 1'b1;
          scan_seq  <= scan_seq + 8'd1;
        end
      end
      if (rd_addr < 4'(NUM_ENTRIES)) begin
        rd_data  <= bank[rd_addr];
        rd_valid <= bank_valid[rd_addr];
      end else begin
        rd_data  <= 24'd0;
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sporta_unpack.sv
//------------------------------------------------------------------------------
// tb_sporta_unpack: randomized frame stimulus against a frame-level model,
// with a queue-based scoreboard for reads and scan pulses.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sporta_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] stream;
  logic        stream_tick;
  logic [3:0]  rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic        scan_done;
  logic [7:0]  scan_seq;
  logic        fmt_err;

  sporta_unpack #(.FAST_BITS(14), .SLOW_BITS(24)) dut (
    .clk(clk), .rst(rst), .stream(stream), .stream_tick(stream_tick),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .scan_done(scan_done), .scan_seq(scan_seq), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [23:0] d;
    logic        v;
  } rd_t;

  rd_t        rd_q[$];
  logic [7:0] seq_q[$];
  int tests = 0;
  int fails = 0;

  logic [23:0] bank_m [12];
  logic        vld_m  [12];
  logic [7:0]  seq_m;

  logic rd_req = 1'b0;
  logic rd_req_q = 1'b0;
  always @(posedge clk) rd_req_q <= rd_req;

  // Monitor: compares whatever the DUT presents against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_req_q) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected: rd_data=%h rd_valid=%b, no expectation queued", rd_data, rd_valid);
        end else begin
          rd_t e;
          e = rd_q.pop_front();
          if (rd_data !== e.d || rd_valid !== e.v) begin
            fails++;
            $display("FAIL rd_addr%0d: got data=%h valid=%b, expected data=%h valid=%b",
                     e.a, rd_data, rd_valid, e.d, e.v);
          end
        end
      end
      if (scan_done === 1'b1) begin
        tests++;
        if (seq_q.size() == 0) begin
          fails++;
          $display("FAIL scan_done_unexpected: scan_seq=%0d, no scan expected", scan_seq);
        end else begin
          logic [7:0] es;
          es = seq_q.pop_front();
          if (scan_seq !== es) begin
            fails++;
            $display("FAIL scan_seq: got %0d, expected %0d", scan_seq, es);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] slot, input logic b0, input logic [7:0] d,
                       input logic last = 1'b0, input logic [1:0] ch = 2'd0);
    @(posedge clk); #1;
    stream      = {ch, last, slot, b0, d};
    stream_tick = 1'b1;
    rd_req      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      stream_tick = 1'b0;
      stream      = 16'($urandom);
      rd_req      = 1'b0;
    end
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [23:0] d, input logic v);
    rd_t e;
    @(posedge clk); #1;
    stream_tick = 1'b0;
    rd_addr     = a;
    rd_req      = 1'b1;
    e.a = a; e.d = d; e.v = v;
    rd_q.push_back(e);
  endtask

  task automatic read_model(input int a);
    if (a < 12) read_chk(4'(a), bank_m[a], vld_m[a]);
    else        read_chk(4'(a), 24'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; stream_tick = 1'b0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin bank_m[i] = 24'd0; vld_m[i] = 1'b0; end
    seq_m = 8'd0;
  endtask

  // Frame-level model: a fast frame on slot 2..9 lands {b1,b2}>>2 in ch slot-2.
  task automatic fast_frame(input int slot, input logic [7:0] b1, input logic [7:0] b2,
                            input int extra = 0, input bit gaps = 1'b0);
    drive(4'(slot), 1'b1, 8'($urandom));
    if (gaps) idle($urandom_range(0, 1));
    drive(4'(slot), 1'b0, b1);
    if (gaps) idle($urandom_range(0, 1));
    drive(4'(slot), 1'b0, b2);
    for (int k = 0; k < extra; k++) drive(4'(slot), 1'b0, 8'($urandom));
    if (slot >= 2 && slot <= 9) begin
      bank_m[slot-2] = 24'({b1, b2} >> 2);
      vld_m[slot-2]  = 1'b1;
      if (slot == 9) begin
        seq_m = seq_m + 8'd1;
        seq_q.push_back(seq_m);
      end
    end
  endtask

  task automatic slow_frame(input logic [1:0] ch, input logic last, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int extra = 0);
    drive(4'd10, 1'b1, 8'($urandom), last, ch);
    drive(4'd10, 1'b0, b1, last, ch);
    drive(4'd10, 1'b0, b2, last, ch);
    drive(4'd10, 1'b0, b3, last, ch);
    for (int k = 0; k < extra; k++) drive(4'd10, 1'b0, 8'($urandom), last, ch);
    if (last) begin
      bank_m[8+int'(ch)] = {b1, b2, b3};
      vld_m[8+int'(ch)]  = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; stream = 16'd0; stream_tick = 1'b0; rd_addr = 4'd0;
    for (int i = 0; i < 12; i++) begin bank_m[i] = 24'd0; vld_m[i] = 1'b0; end
    seq_m = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_fmt_err", 32'(fmt_err), 32'd0);
    chk("reset_scan_done", 32'(scan_done), 32'd0);
    chk("reset_scan_seq", 32'(scan_seq), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    for (int a = 0; a < 16; a++) read_model(a);

    // Slot 3 frame: same-cycle read sees old value, next cycle sees new one.
    drive(4'd3, 1'b1, 8'h00);
    drive(4'd3, 1'b0, 8'hAB);
    drive(4'd3, 1'b0, 8'hCD);
    read_chk(4'd1, 24'd0, 1'b0);
    read_chk(4'd1, 24'h002AF3, 1'b1);
    bank_m[1] = 24'h002AF3; vld_m[1] = 1'b1;

    // Full scan of slots 0-9 back to back.
    for (int s = 0; s < 10; s++) begin
      if (s == 9) fast_frame(s, 8'hFF, 8'hFC);
      else        fast_frame(s, 8'($urandom), 8'($urandom));
    end
    idle(3);
    read_chk(4'd7, 24'h003FFF, 1'b1);
    idle(1);
    chk("scan_seq_first", 32'(scan_seq), 32'd1);
    for (int a = 0; a < 8; a++) read_model(a);

    // Slow channel 2 then a config-phase frame that must not write.
    slow_frame(2'd2, 1'b1, 8'h12, 8'h34, 8'h56);
    idle(2);
    read_chk(4'd10, 24'h123456, 1'b1);
    slow_frame(2'd2, 1'b0, 8'hAA, 8'hBB, 8'hCC);
    idle(2);
    read_chk(4'd10, 24'h123456, 1'b1);

    // Randomized frame mix.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0)
        fast_frame($urandom_range(0, 9), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 2), 1'b1);
      else
        slow_frame(2'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), $urandom_range(0, 2));
      idle($urandom_range(0, 2));
    end
    idle(3);
    for (int a = 0; a < 16; a++) read_model(a);
    idle(1);
    chk("fmt_err_clean_stream", 32'(fmt_err), 32'd0);

    // Run scans until scan_seq wraps back to 0.
    for (int g = 0; g < 300 && seq_m != 8'd0; g++)
      fast_frame(9, 8'($urandom), 8'($urandom));
    idle(3);
    chk("scan_seq_wrap", 32'(scan_seq), 32'd0);

    // Reset between byte idx 1 and 2 of slot 4.
    do_reset();
    drive(4'd4, 1'b1, 8'h00);
    drive(4'd4, 1'b0, 8'h11);
    @(posedge clk); #1;
    rst = 1'b1; stream_tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'd4, 1'b0, 8'h22);
    drive(4'd4, 1'b0, 8'h33);
    idle(3);
    read_chk(4'd2, 24'd0, 1'b0);
    fast_frame(4, 8'h5A, 8'hC3);
    idle(3);
    read_chk(4'd2, 24'h0016B0, 1'b1);

    // Slot 12 sets fmt_err and is dropped without moving the byte index.
    drive(4'd5, 1'b1, 8'h00);
    drive(4'd5, 1'b0, 8'h81);
    drive(4'd12, 1'b0, 8'hEE);
    drive(4'd5, 1'b0, 8'h7F);
    idle(1);
    @(negedge clk);
    chk("fmt_err_slot12", 32'(fmt_err), 32'd1);
    idle(2);
    read_chk(4'd3, 24'h00205F, 1'b1);
    bank_m[3] = 24'h00205F; vld_m[3] = 1'b1;
    fast_frame(6, 8'($urandom), 8'($urandom));
    idle(2);
    @(negedge clk);
    chk("fmt_err_sticky", 32'(fmt_err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("fmt_err_cleared", 32'(fmt_err), 32'd0);

    // Byte index overflow: 14 ticks are legal, the 15th saturates.
    for (int k = 0; k < 14; k++) drive(4'd0, 1'b0, 8'($urandom));
    idle(1);
    @(negedge clk);
    chk("fmt_err_bidx14", 32'(fmt_err), 32'd0);
    for (int k = 0; k < 3; k++) drive(4'd0, 1'b0, 8'($urandom));
    idle(1);
    @(negedge clk);
    chk("fmt_err_bidx17", 32'(fmt_err), 32'd1);

    idle(4);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("scan_queue_drained", 32'(seq_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
